// File: rtl/pred_port_arb_pkg.sv
// Shared types for the branch-predictor port arbiter: update record, arbiter states, helpers.
package pred_port_arb_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            success;
        logic            failed;
    } pred_upd_t;

    typedef enum logic {
        ARB_LOOKUP = 1'b0,
        ARB_DRAIN  = 1'b1
    } pred_arb_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/pred_port_arb_if.sv
// Fetch, branch-unit and predictor-table signals of the predictor port arbiter.
interface pred_port_arb_if;
    import pred_port_arb_pkg::*;

    logic            flush_i;
    logic            fe_req_v_i;
    logic [XLEN-1:0] fe_req_pc_i;
    logic            fe_req_rdy_o;
    logic            fe_rsp_v_o;
    logic            fe_rsp_hit_o;
    logic            fe_rsp_taken_o;
    logic [XLEN-1:0] fe_rsp_target_o;
    logic            bu_upd_v_i;
    logic            bu_upd_rdy_o;
    logic [XLEN-1:0] bu_upd_pc_i;
    logic [XLEN-1:0] bu_upd_target_i;
    logic            bu_upd_success_i;
    logic            bu_upd_failed_i;
    logic            pred_en_o;
    logic [XLEN-1:0] pred_pc_branch_o;
    logic [XLEN-1:0] pred_pc_target_o;
    logic            pred_success_o;
    logic            pred_failed_o;
    logic [XLEN-1:0] pred_pc_i;
    logic            pred_taken_i;
    logic            pred_v_i;

    modport slave (
        input  flush_i, fe_req_v_i, fe_req_pc_i,
        output fe_req_rdy_o, fe_rsp_v_o, fe_rsp_hit_o, fe_rsp_taken_o, fe_rsp_target_o,
        input  bu_upd_v_i, bu_upd_pc_i, bu_upd_target_i, bu_upd_success_i, bu_upd_failed_i,
        output bu_upd_rdy_o,
        output pred_en_o, pred_pc_branch_o, pred_pc_target_o, pred_success_o, pred_failed_o,
        input  pred_pc_i, pred_taken_i, pred_v_i
    );

    modport master (
        output flush_i, fe_req_v_i, fe_req_pc_i,
        input  fe_req_rdy_o, fe_rsp_v_o, fe_rsp_hit_o, fe_rsp_taken_o, fe_rsp_target_o,
        output bu_upd_v_i, bu_upd_pc_i, bu_upd_target_i, bu_upd_success_i, bu_upd_failed_i,
        input  bu_upd_rdy_o,
        input  pred_en_o, pred_pc_branch_o, pred_pc_target_o, pred_success_o, pred_failed_o,
        output pred_pc_i, pred_taken_i, pred_v_i
    );

endinterface

// File: rtl/pred_port_arb_chk.sv
// Simulation checks on branch-unit update inputs.
module pred_port_arb_chk (
    input logic clk,
    input logic reset_n,
    input logic upd_v,
    input logic upd_success,
    input logic upd_failed
);
    a_upd_outcome_excl: assert property (@(posedge clk) disable iff (!reset_n)
        upd_v |-> !(upd_success && upd_failed));
endmodule

// File: rtl/pred_upd_fifo.sv
// Branch-update FIFO; head is read straight from storage, so a pushed entry pops next cycle at the earliest.
module pred_upd_fifo
    import pred_port_arb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pred_upd_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  T                       push_data_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output T                       head_o
);
    localparam int PW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push_s, do_pop_s;

    assign full_o    = (count_q == (PW + 1)'(DEPTH));
    assign empty_o   = (count_q == (PW + 1)'(0));
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];

    // Storage, pointers (wrap naturally at the power-of-two depth) and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + (PW + 1)'(do_push_s) - (PW + 1)'(do_pop_s);
        end
    end

endmodule

// File: rtl/pred_port_arb.sv
// Shares the branch-predictor port between fetch lookups and buffered BU updates.
// Define PRED_ARB_STATS_EN to add the stat_lkp_stall_o / stat_upd_full_o counters.
module pred_port_arb
    import pred_port_arb_pkg::*;
#(
    parameter int UPD_DEPTH  = 4,
    parameter int HI_WM      = UPD_DEPTH - 1,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    pred_port_arb_if.slave bus
`ifdef PRED_ARB_STATS_EN
    ,
    output logic [31:0]    stat_lkp_stall_o,
    output logic [31:0]    stat_upd_full_o
`endif
);
    localparam int CW = $clog2(UPD_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    pred_arb_state_e state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            rst_done_q;
    logic [CW-1:0]   count_s;
    logic            full_s, empty_s, push_s, pop_s, grant_s, fe_rdy_s, bu_rdy_s, force_s;
    pred_upd_t       upd_in_s, head_s;
    logic            grant_q, kill_q, hit_q, taken_q;
    logic [XLEN-1:0] target_q;
    logic            pred_en_s, pred_succ_s, pred_fail_s;
    logic [XLEN-1:0] pred_pcb_s, pred_tgt_s;

    assign bu_rdy_s = rst_done_q & ~full_s;
    assign push_s   = bus.bu_upd_v_i & bu_rdy_s;
    assign upd_in_s = '{pc: bus.bu_upd_pc_i, target: bus.bu_upd_target_i,
                        success: bus.bu_upd_success_i, failed: bus.bu_upd_failed_i};

    pred_upd_fifo #(.DEPTH(UPD_DEPTH), .T(pred_upd_t)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_s),
        .push_data_i (upd_in_s),
        .pop_i       (pop_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (count_s),
        .head_o      (head_s)
    );

    // Holds both handshakes low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_done_q <= 1'b0;
        else          rst_done_q <= 1'b1;
    end

    // Arbiter state and starvation counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_LOOKUP;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Port ownership for this cycle and next-state selection.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        force_s  = 1'b0;
        fe_rdy_s = 1'b0;
        grant_s  = 1'b0;
        pop_s    = 1'b0;
        case (state_q)
            ARB_LOOKUP: begin
                force_s  = (starve_q >= SW'(STARVE_MAX)) & ~empty_s;
                fe_rdy_s = rst_done_q & ~force_s;
                grant_s  = fe_rdy_s & bus.fe_req_v_i;
                pop_s    = ~grant_s & ~empty_s;
                if (count_s >= CW'(HI_WM)) state_d = ARB_DRAIN;
                else                       state_d = ARB_LOOKUP;
            end
            ARB_DRAIN: begin
                pop_s = ~empty_s;
                // Leave only once this cycle's push/pop has emptied the FIFO.
                if ((count_s + CW'(push_s) - CW'(pop_s)) == CW'(0)) state_d = ARB_LOOKUP;
                else                                                 state_d = ARB_DRAIN;
            end
            default: state_d = ARB_LOOKUP;
        endcase
        if (pop_s)                   starve_d = '0;
        else if (grant_s & ~empty_s) starve_d = starve_q + SW'(1);
        else                         starve_d = starve_q;
    end

    // Predictor port mux: lookup PC, FIFO head update, or idle zeros.
    always_comb begin
        pred_en_s   = 1'b0;
        pred_pcb_s  = '0;
        pred_tgt_s  = '0;
        pred_succ_s = 1'b0;
        pred_fail_s = 1'b0;
        if (grant_s) begin
            pred_pcb_s = bus.fe_req_pc_i;
        end else if (pop_s) begin
            pred_en_s   = 1'b1;
            pred_pcb_s  = head_s.pc;
            pred_tgt_s  = head_s.target;
            pred_succ_s = head_s.success;
            pred_fail_s = head_s.failed;
        end else begin
            pred_en_s = 1'b0;
        end
    end

    // Lookup response captured from the combinational predictor in the grant cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q  <= 1'b0;
            kill_q   <= 1'b0;
            hit_q    <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            grant_q <= grant_s;
            kill_q  <= grant_s & bus.flush_i;
            if (grant_s) begin
                hit_q    <= bus.pred_v_i;
                taken_q  <= bus.pred_taken_i;
                target_q <= bus.pred_pc_i;
            end
        end
    end

    assign bus.fe_req_rdy_o     = fe_rdy_s;
    assign bus.bu_upd_rdy_o     = bu_rdy_s;
    assign bus.fe_rsp_v_o       = grant_q & ~kill_q;
    assign bus.fe_rsp_hit_o     = hit_q;
    assign bus.fe_rsp_taken_o   = taken_q;
    assign bus.fe_rsp_target_o  = target_q;
    assign bus.pred_en_o        = pred_en_s;
    assign bus.pred_pc_branch_o = pred_pcb_s;
    assign bus.pred_pc_target_o = pred_tgt_s;
    assign bus.pred_success_o   = pred_succ_s;
    assign bus.pred_failed_o    = pred_fail_s;

    pred_port_arb_chk u_chk (
        .clk         (clk),
        .reset_n     (reset_n),
        .upd_v       (bus.bu_upd_v_i),
        .upd_success (bus.bu_upd_success_i),
        .upd_failed  (bus.bu_upd_failed_i)
    );

`ifdef PRED_ARB_STATS_EN
    logic [31:0] stall_cnt_q, full_cnt_q;

    // Saturating counters of stalled lookups and refused updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
            full_cnt_q  <= 32'd0;
        end else begin
            if (bus.fe_req_v_i & ~fe_rdy_s) stall_cnt_q <= sat_inc32(stall_cnt_q);
            if (bus.bu_upd_v_i & ~bu_rdy_s) full_cnt_q  <= sat_inc32(full_cnt_q);
        end
    end

    assign stat_lkp_stall_o = stall_cnt_q;
    assign stat_upd_full_o  = full_cnt_q;
`endif

endmodule
